// File: rtl/mux_rr_sched.sv
// Round-robin select generator for a 4:1 mux; captures the selected word onto a valid/ready port.
// Latency: sel updates on the request edge, word captured one edge later (one word per 2 cycles).
// Backpressure: a captured word is held with sel frozen until out_ready; no arbitration meanwhile.
module mux_rr_sched #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] y_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] gnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUT
    } state_t;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    last, last_nxt;
    logic [SEL_W-1:0]    sel_nxt;
    logic [SEL_W-1:0]    win;
    logic [DATA_W-1:0]   data_nxt;
    logic                valid_nxt;
    logic [NUM_CH-1:0]   gnt_nxt;
    logic                any_req;

    assign any_req = |req;

    // Scan downward so the smallest offset from last+1 wins; offset NUM_CH wraps to last itself.
    always_comb begin
        win = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[last + SEL_W'(i)]) begin
                win = last + SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        gnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_nxt   = win;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // sel was registered last edge, so y_in has had a full cycle to settle.
                data_nxt  = y_in;
                valid_nxt = 1'b1;
                gnt_nxt   = NUM_CH'(1) << sel;
                last_nxt  = sel;
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    if (any_req) begin
                        sel_nxt   = win;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            last      <= SEL_W'(NUM_CH - 1);
            out_data  <= '0;
            out_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            last      <= last_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            gnt       <= gnt_nxt;
        end
    end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
Round-robin scheduler that sits directly upstream and downstream of the 4:1 mux. It arbitrates among four per-channel request lines and drives the mux select. It then captures the mux output one cycle later and presents it on a valid/ready output port. A one-hot grant pulse tells the winning source its word was consumed.

Parameters:
NUM_CH, 4, number of mux channels; fixed at 4 for this revision.
SEL_W, 2, select width; equals log2(NUM_CH).
DATA_W, 4, data width of the mux input and output.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  NUM_CH  level request per channel; bit0=a, bit1=b, bit2=c, bit3=d
sel  output  SEL_W  registered select, driven to the mux sel
y_in  input  DATA_W  mux output y, fed back combinationally
out_data  output  DATA_W  captured word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
gnt  output  NUM_CH  one-hot, one-cycle pulse naming the channel just captured

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: sel=0, out_data=0, out_valid=0, gnt=0, internal last=3 (so channel 0 has first priority), state=IDLE.
- Reset mid-operation: any in-flight or held word is discarded; all outputs return to their reset values at that edge.
- Arbitration: winner w = first set bit of req, scanning (last+1) mod 4 upward with wrap. With req=0 there is no winner.
- FSM states: IDLE, SETTLE, OUT.
- IDLE, req!=0: sel<=w; go to SETTLE.
- IDLE, req==0: stay in IDLE; outputs unchanged.
- SETTLE (always exactly one cycle): out_data<=y_in, out_valid<=1, gnt<=onehot(w), last<=w; go to OUT.
- SETTLE: req is not re-sampled; a request dropping during SETTLE does not abort the capture.
- OUT: out_valid and out_data held stable; sel held.
- OUT, out_ready=0: stay in OUT.
- OUT, out_ready=1 and req!=0: arbitrate from the updated last; sel<=w_new, out_valid<=0; go to SETTLE (back-to-back).
- OUT, out_ready=1 and req==0: out_valid<=0; go to IDLE.
- gnt: high only in the single cycle after the SETTLE edge; zero at all other times.
- sel changes only on the IDLE->SETTLE or OUT->SETTLE edge, so y_in is stable for the full SETTLE cycle.
- Latency: req first sampled high in IDLE at edge N gives sel updated at N, capture at N+1, out_valid high from N+1.
- Throughput: one word per 2 cycles when continuously ready.
- Handshake rule: transfer occurs on a rising edge with out_valid=1 and out_ready=1.
- Handshake rule: out_valid never drops without a transfer, except on reset.
- Handshake rule: out_valid does not depend combinationally on out_ready.
- Width rules: sel is the plain binary channel index. out_data is a direct copy of y_in; no arithmetic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0 for 10 cycles -> out_valid=0, gnt=0, sel=0 throughout.
- Basic capture: a=4'h3, req=4'b0001, out_ready=1 -> sel=0, then out_data=4'h3 with out_valid=1 two cycles after req.
- Basic capture (grant): same stimulus -> gnt=4'b0001 for exactly one cycle.
- Round-robin fairness: a..d=1,2,4,8, req=4'b1111 held, out_ready=1 -> out_data sequence 1,2,4,8,1 at a 2-cycle spacing.
- Round-robin fairness (grant): same stimulus -> gnt sequence 0001,0010,0100,1000,0001.
- Backpressure: word 4'hC captured from channel c, out_ready=0 for 5 cycles -> out_valid=1 and out_data=4'hC held, sel=2 held, gnt=0, no new capture.
- Backpressure release: raise out_ready -> single transfer, then the next arbitration starts from channel d.
- Skip and wrap: last=2, req=4'b0011 -> channel 0 wins (sel=0), then channel 1.
- Single-requester repeat: req=4'b0010 held -> channel 1 granted repeatedly (sel=1) under wrap.
- Reset mid-OUT: rst=1 for one cycle while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, sel=0.
- Post-reset priority: after the mid-OUT reset, the first grant goes to the lowest requesting channel starting from 0.
